// File: rtl/dma_pkg.sv
// Shared types and constants for the UART DMA loader.
// Phase state encoding, default ack byte, word geometry and count clamp.
package dma_pkg;

    typedef enum logic [1:0] {
        S_HDR,
        S_CODE,
        S_ACK,
        S_DATA
    } state_t;

    localparam logic [7:0] ACK_BYTE_DEF = 8'hAA;
    localparam int         WORD_BYTES   = 4;

    // Limit a header count to the code segment capacity.
    function automatic logic [31:0] clamp_count(
        input logic [31:0] n,
        input logic [31:0] cap
    );
        return (n > cap) ? cap : n;
    endfunction

endpackage

// File: rtl/uart_word_assembler.sv
// Packs received UART bytes into little-endian 32-bit words.
// Ports: clock, reset, rx_ready/rdata (byte in), word_valid/word (combinational,
// valid in the cycle of the 4th byte). Optional macro UART_DMA_BYTE_TIMEOUT_EN
// adds an inter-byte gap counter that discards a stalled partial word.
module uart_word_assembler
    import dma_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_ready,
    input  logic [7:0]  rdata,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    logic [1:0]  byte_cnt;
    logic [23:0] shift_reg;
    logic        last;
    logic        timeout;

    assign last       = rx_ready && (byte_cnt == LAST_BYTE);
    // The top byte comes straight from rdata so the word is usable in the
    // same cycle as the final byte, giving one cycle of output latency.
    assign word_valid = last;
    assign word       = {rdata, shift_reg};

`ifdef UART_DMA_BYTE_TIMEOUT_EN
    localparam logic [31:0] GAP_LIMIT = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] gap;

    assign timeout = (byte_cnt != 2'd0) && !rx_ready && (gap == GAP_LIMIT);

    always_ff @(posedge clock) begin
        if (reset || rx_ready || byte_cnt == 2'd0 || timeout) begin
            gap <= 32'd0;
        end else begin
            gap <= gap + 32'd1;
        end
    end
`else
    wire unused_timeout_cfg = ^TIMEOUT_CYCLES;

    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt  <= 2'd0;
            shift_reg <= 24'd0;
        end else if (rx_ready) begin
            if (!last) begin
                shift_reg[{byte_cnt, 3'b000} +: 8] <= rdata;
            end
            // Two-bit counter wraps to 0 after the 4th byte.
            byte_cnt <= byte_cnt + 2'd1;
        end else if (timeout) begin
            byte_cnt <= 2'd0;
        end
    end

endmodule

// File: rtl/uart_dma_loader.sv
// DMA producer: boot header + code words as instr_ready, then one ack byte
// over UART, then all further words as mem_ready until reset.
// Ports: clock, reset, rx_ready/rdata (UART rx), instr_ready/mem_ready/data
// (word pulses), program_loaded, tx_start/sdata/tx_busy (UART tx handshake).
// Optional macro UART_DMA_BYTE_TIMEOUT_EN enables the partial-word timeout.
module uart_dma_loader
    import dma_pkg::*;
#(
    parameter int unsigned MAX_INSTR_WORDS = 256,
    parameter logic [7:0]  ACK_BYTE        = ACK_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYCLES  = 1_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_ready,
    input  logic [7:0]  rdata,
    output logic        instr_ready,
    output logic        mem_ready,
    output logic [31:0] data,
    output logic        program_loaded,
    output logic        tx_start,
    output logic [7:0]  sdata,
    input  logic        tx_busy
);

    localparam logic [31:0] MAX_WORDS = 32'(MAX_INSTR_WORDS);

    state_t      state;
    logic [31:0] remaining;
    logic [31:0] drop;
    logic        word_valid;
    logic [31:0] word;
    logic [31:0] hdr_keep;

    uart_word_assembler #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_asm (
        .clock      (clock),
        .reset      (reset),
        .rx_ready   (rx_ready),
        .rdata      (rdata),
        .word_valid (word_valid),
        .word       (word)
    );

    assign hdr_keep = clamp_count(word, MAX_WORDS);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_HDR;
            remaining      <= 32'd0;
            drop           <= 32'd0;
            instr_ready    <= 1'b0;
            mem_ready      <= 1'b0;
            data           <= 32'd0;
            program_loaded <= 1'b0;
            tx_start       <= 1'b0;
            sdata          <= 8'd0;
        end else begin
            instr_ready <= 1'b0;
            mem_ready   <= 1'b0;
            tx_start    <= 1'b0;

            unique case (state)
                S_HDR: begin
                    if (word_valid) begin
                        remaining <= hdr_keep;
                        drop      <= word - hdr_keep;
                        state     <= (word == 32'd0) ? S_ACK : S_CODE;
                    end
                end
                S_CODE: begin
                    if (word_valid) begin
                        if (remaining != 32'd0) begin
                            instr_ready <= 1'b1;
                            data        <= word;
                            remaining   <= remaining - 32'd1;
                            if (remaining == 32'd1 && drop == 32'd0) begin
                                state <= S_ACK;
                            end
                        end else if (drop != 32'd0) begin
                            drop <= drop - 32'd1;
                            if (drop == 32'd1) begin
                                state <= S_ACK;
                            end
                        end
                    end
                end
                S_ACK: begin
                    // Early data words are not lost while waiting on the tx.
                    if (word_valid) begin
                        mem_ready <= 1'b1;
                        data      <= word;
                    end
                    if (!tx_busy) begin
                        tx_start       <= 1'b1;
                        sdata          <= ACK_BYTE;
                        program_loaded <= 1'b1;
                        state          <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (word_valid) begin
                        mem_ready <= 1'b1;
                        data      <= word;
                    end
                end
                default: state <= S_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_dma_loader.sv
// Scoreboard bench for uart_dma_loader (MAX_INSTR_WORDS=2, TIMEOUT_CYCLES=100).
// Expected pulses are queued at stimulus time and popped by a negedge monitor.
module tb_uart_dma_loader;

    localparam int KIND_INSTR = 0;
    localparam int KIND_MEM   = 1;
    localparam int KIND_ACK   = 2;

    typedef struct {
        int          kind;
        logic [31:0] value;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_ready = 1'b0;
    logic [7:0]  rdata = 8'd0;
    logic        instr_ready;
    logic        mem_ready;
    logic [31:0] data;
    logic        program_loaded;
    logic        tx_start;
    logic [7:0]  sdata;
    logic        tx_busy = 1'b0;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   acks_seen = 0;
    logic prev_tx = 1'b0;

    always #5 clock = ~clock;

    uart_dma_loader #(
        .MAX_INSTR_WORDS (2),
        .ACK_BYTE        (8'hAA),
        .TIMEOUT_CYCLES  (100)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .rx_ready       (rx_ready),
        .rdata          (rdata),
        .instr_ready    (instr_ready),
        .mem_ready      (mem_ready),
        .data           (data),
        .program_loaded (program_loaded),
        .tx_start       (tx_start),
        .sdata          (sdata),
        .tx_busy        (tx_busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [31:0] value);
        exp_t e;
        e.kind  = kind;
        e.value = value;
        q.push_back(e);
    endtask

    task automatic pop_and_check(input string tag, input int kind,
                                 input logic [31:0] value);
        exp_t e;
        check({tag, "_pending"}, 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            check({tag, "_kind"}, 32'(kind), 32'(e.kind));
            check({tag, "_value"}, value, e.value);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (instr_ready) begin
                check("instr_excl", 32'(mem_ready), 32'd0);
                pop_and_check("instr", KIND_INSTR, data);
            end
            if (mem_ready) begin
                pop_and_check("mem", KIND_MEM, data);
            end
            if (tx_start) begin
                acks_seen++;
                check("tx_single", 32'(prev_tx), 32'd0);
                check("ack_loaded", 32'(program_loaded), 32'd1);
                pop_and_check("ack", KIND_ACK, 32'(sdata));
            end
            prev_tx <= tx_start;
        end else begin
            prev_tx <= 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_ready = 1'b1;
        rdata    = b;
        @(negedge clock);
        rx_ready = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clock);
            n++;
        end
        repeat (5) @(negedge clock);
        check({tag, "_drained"}, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset = 1'b1;
        rx_ready = 1'b0;
        tx_busy  = 1'b0;
        repeat (2) @(negedge clock);
        check({tag, "_instr"}, 32'(instr_ready), 32'd0);
        check({tag, "_mem"}, 32'(mem_ready), 32'd0);
        check({tag, "_tx"}, 32'(tx_start), 32'd0);
        check({tag, "_loaded"}, 32'(program_loaded), 32'd0);
        check({tag, "_data"}, data, 32'd0);
        check({tag, "_sdata"}, 32'(sdata), 32'd0);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset("rst0");

        // Two-word program then ack.
        expect_ev(KIND_INSTR, 32'h1122_3344);
        expect_ev(KIND_INSTR, 32'hDEAD_BEEF);
        expect_ev(KIND_ACK, 32'h0000_00AA);
        send_word(32'd2);
        send_word(32'h1122_3344);
        send_word(32'hDEAD_BEEF);
        drain("prog2");
        check("prog2_loaded", 32'(program_loaded), 32'd1);

        // Empty program: immediate ack, then data.
        do_reset("rst1");
        expect_ev(KIND_ACK, 32'h0000_00AA);
        send_word(32'd0);
        drain("hdr0_ack");
        expect_ev(KIND_MEM, 32'd5);
        send_word(32'd5);
        drain("hdr0_data");

        // Transmitter busy when the ack becomes due.
        do_reset("rst2");
        tx_busy = 1'b1;
        acks_seen = 0;
        expect_ev(KIND_INSTR, 32'hCAFE_F00D);
        expect_ev(KIND_MEM, 32'h1234_5678);
        expect_ev(KIND_ACK, 32'h0000_00AA);
        send_word(32'd1);
        send_word(32'hCAFE_F00D);
        send_word(32'h1234_5678);
        repeat (50) @(negedge clock);
        check("busy_no_ack", 32'(acks_seen), 32'd0);
        check("busy_not_loaded", 32'(program_loaded), 32'd0);
        tx_busy = 1'b0;
        drain("busy");
        check("busy_one_ack", 32'(acks_seen), 32'd1);

        // Header larger than capacity: extra words dropped.
        do_reset("rst3");
        expect_ev(KIND_INSTR, 32'hA0A0_0001);
        expect_ev(KIND_INSTR, 32'hA0A0_0002);
        expect_ev(KIND_ACK, 32'h0000_00AA);
        send_word(32'd4);
        for (int i = 1; i <= 4; i++) begin
            send_word(32'hA0A0_0000 | 32'(i));
        end
        drain("clamp");
        expect_ev(KIND_MEM, 32'hA0A0_0005);
        send_word(32'hA0A0_0005);
        drain("clamp_data");

        // Reset in the middle of the second code word.
        do_reset("rst4");
        expect_ev(KIND_INSTR, 32'h0BAD_F00D);
        send_word(32'd2);
        send_word(32'h0BAD_F00D);
        send_byte(8'h77);
        send_byte(8'h66);
        drain("mid_pre");
        do_reset("rst_mid");
        expect_ev(KIND_INSTR, 32'h5555_AAAA);
        expect_ev(KIND_ACK, 32'h0000_00AA);
        send_word(32'd1);
        send_word(32'h5555_AAAA);
        drain("mid_post");

        // Stalled partial word in the data phase.
        do_reset("rst5");
        expect_ev(KIND_ACK, 32'h0000_00AA);
        send_word(32'd0);
        drain("gap_ack");
`ifdef UART_DMA_BYTE_TIMEOUT_EN
        expect_ev(KIND_MEM, 32'h0403_0201);
`else
        expect_ev(KIND_MEM, 32'h0199_8877);
`endif
        send_byte(8'h77);
        send_byte(8'h88);
        send_byte(8'h99);
        repeat (150) @(negedge clock);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        drain("gap");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_dma_loader.md
Name: uart_dma_loader

Overview:
- Producer side of the hub's DMA interface.
- Takes the byte stream from the UART receiver and assembles little-endian 32-bit words.
- Boot phase: words are emitted as instruction-store pulses (instr_ready). After the program completes, sends one ack byte through the shared UART transmitter.
- Data phase: every later word is emitted as an input-data pulse (mem_ready). This phase lasts until reset.

Parameters:
- MAX_INSTR_WORDS, 256, capacity of the code segment; larger header counts are clamped to this.
- ACK_BYTE, 8'hAA, byte sent once the program is fully loaded.
- TIMEOUT_CYCLES, 1_000_000, inter-byte gap that abandons a partial word (used only when the optional feature is compiled in).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- rx_ready  in  1  one-cycle pulse from the UART receiver; rdata is valid in the same cycle
- rdata  in  8  received byte
- instr_ready  out  1  one-cycle pulse: data holds an instruction word
- mem_ready  out  1  one-cycle pulse: data holds an input-data word
- data  out  32  last assembled word
- program_loaded  out  1  high from ack issue until reset
- tx_start  out  1  one-cycle pulse requesting the UART transmitter
- sdata  out  8  byte to transmit
- tx_busy  in  1  transmitter busy

Behaviour:
- Reset values: instr_ready=0, mem_ready=0, tx_start=0, program_loaded=0, data=0, sdata=0. State=S_HDR, byte_cnt=0, remaining=0, drop=0.

Word assembly (all states):
- On rx_ready, byte k (0..3) is written to shift_reg[8k+7:8k] and byte_cnt is incremented.
- On the 4th byte, the word is complete: byte_cnt returns to 0 and the word is dispatched per state on the next edge. Latency is 1 cycle after the 4th rx_ready.
- data updates with the pulse and holds until the next completed word.

States:
- S_HDR: a completed word is the count N. It is not pulsed out.
  - remaining = min(N, MAX_INSTR_WORDS); drop = N - remaining.
  - N==0: go to S_ACK.
  - Otherwise: go to S_CODE.
- S_CODE:
  - While remaining>0: each completed word pulses instr_ready, then remaining is decremented.
  - Once remaining==0 with drop>0: further words are discarded (no pulse) and drop is decremented.
  - When the final word is consumed (both counters 0), go to S_ACK.
- S_ACK:
  - On the first cycle with tx_busy==0: tx_start=1 for one cycle, sdata=ACK_BYTE, program_loaded=1, go to S_DATA.
  - Bytes arriving in S_ACK are still assembled. A word completed here pulses mem_ready (it is treated as data-phase data).
- S_DATA: each completed word pulses mem_ready. No exit except reset.

Output and arithmetic rules:
- instr_ready and mem_ready are never high in the same cycle.
- tx_start is never high for two consecutive cycles.
- N is treated as unsigned 32-bit. The counters are 32-bit and never underflow.

Boundaries and corner cases:
- rx_ready arriving in the same cycle as a dispatch: the new byte becomes byte 0 of the next word, with no loss.
- Reset mid-word or mid-program: all state is cleared and the partial word is discarded. The next byte is header byte 0.

Optional Feature:
- Macro: UART_DMA_BYTE_TIMEOUT_EN.
- Defined:
  - A 32-bit gap counter runs while byte_cnt!=0 and clears on every rx_ready.
  - When it reaches TIMEOUT_CYCLES, byte_cnt is reset to 0 and the partial word is discarded. No pulse is produced and state and counters are unchanged.
- Undefined: there is no gap counter, and a partial word waits indefinitely.

Decomposition:
- Shared package dma_pkg:
  - State enum: S_HDR, S_CODE, S_ACK, S_DATA.
  - Constants: the default ACK_BYTE and WORD_BYTES=4.
- One natural sub-module, uart_word_assembler:
  - Handles the byte counter, shift register, word_valid pulse, and the optional timeout.
  - The parent holds the phase FSM and the ack/transmit handshake.

Test Plan:
- Header 02 00 00 00, then words 0x11223344 and 0xDEADBEEF sent LSB first:
  - Two instr_ready pulses with data=0x11223344 then 0xDEADBEEF.
  - Then tx_start with sdata=0xAA and program_loaded=1.
- Header 0:
  - No instr_ready.
  - Ack is issued immediately; the next word 0x00000005 produces mem_ready with data=5.
- tx_busy held high for 50 cycles when entering S_ACK:
  - tx_start is delayed until the first cycle with tx_busy=0.
  - One word received during the wait still produces mem_ready.
- MAX_INSTR_WORDS=2, header N=4, 4 code words:
  - 2 instr_ready pulses and 2 words silently dropped.
  - Ack follows the 4th word; the 5th word produces mem_ready.
- Reset asserted after 2 bytes of the second code word:
  - All outputs return to 0.
  - The new header 01 00 00 00 plus one word loads correctly.
- With UART_DMA_BYTE_TIMEOUT_EN and TIMEOUT_CYCLES=100:
  - Send 3 bytes, idle 150 cycles, then send 4 bytes 01 02 03 04.
  - Exactly one word is produced, 0x04030201; the first 3 bytes are discarded.
